sqrt_32b_pipe: RTL and testbench

//  Pipelined integer square root for 32-bit unsigned operands. It is the inverse
//  of the 16-bit pipelined squarer: root = floor(sqrt(X)), rem = X - root^2.

---
 rtl/sqrt_32b_pipe.sv | 92 +++++++++
 tb/tb_sqrt_32b_pipe.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/sqrt_32b_pipe.sv
// Pipelined integer square root: root = floor(sqrt(X)), rem = X - root^2.
// Non-restoring digit-by-digit recurrence, BITS_PER_STAGE root bits per register stage.
module sqrt_32b_pipe #(
    parameter int unsigned W_OUT          = 16,
    parameter int unsigned BITS_PER_STAGE = 4
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    input  logic                 Enable,
    input  logic                 in_valid,
    input  logic [2*W_OUT-1:0]   X,
    output logic                 out_valid,
    output logic [W_OUT-1:0]     root,
    output logic [W_OUT:0]       rem
);
    localparam int unsigned LAT = W_OUT / BITS_PER_STAGE;

    // rem is a two's-complement partial remainder; its MSB is the sign
    typedef struct packed {
        logic [2*W_OUT-1:0] x;
        logic [W_OUT-1:0]   root;
        logic [W_OUT+1:0]   rem;
    } stage_t;

    function automatic stage_t step(input stage_t s);
        stage_t           r;
        logic [W_OUT+1:0] t;
        r = s;
        for (int unsigned i = 0; i < BITS_PER_STAGE; i++) begin
            t = {r.rem[W_OUT-1:0], r.x[2*W_OUT-1 -: 2]};
            if (r.rem[W_OUT+1])
                t = t + {r.root, 2'b11};
            else
                t = t - {r.root, 2'b01};
            r.root = {r.root[W_OUT-2:0], ~t[W_OUT+1]};
            r.x    = r.x << 2;
            r.rem  = t;
        end
        return r;
    endfunction

    // Last stage: remaining iterations plus the sign correction of the remainder
    function automatic logic [2*W_OUT:0] finish(input stage_t s);
        stage_t r;
        r = step(s);
        if (r.rem[W_OUT+1])
            r.rem = r.rem + {1'b0, r.root, 1'b1};
        return {r.root, r.rem[W_OUT:0]};
    endfunction

    stage_t             s_in;
    stage_t             st_d [LAT-1];
    stage_t             st_q [LAT-1];
    logic [LAT-2:0]     vld_q;
    logic [W_OUT-1:0]   root_d, root_q;
    logic [W_OUT:0]     rem_d, rem_q;
    logic               out_valid_q;

    always_comb begin
        s_in.x    = X;
        s_in.root = '0;
        s_in.rem  = '0;
        st_d[0]   = step(s_in);
        for (int unsigned k = 1; k < LAT - 1; k++)
            st_d[k] = step(st_q[k-1]);
        {root_d, rem_d} = finish(st_q[LAT-2]);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int unsigned k = 0; k < LAT - 1; k++)
                st_q[k] <= '0;
            vld_q       <= '0;
            root_q      <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (Enable) begin
            st_q     <= st_d;
            vld_q[0] <= in_valid;
            for (int unsigned k = 1; k < LAT - 1; k++)
                vld_q[k] <= vld_q[k-1];
            root_q      <= root_d;
            rem_q       <= rem_d;
            out_valid_q <= vld_q[LAT-2];
        end
    end

    assign out_valid = out_valid_q;
    assign root      = root_q;
    assign rem       = rem_q;

endmodule

// File: tb/tb_sqrt_32b_pipe.sv
// Self-checking bench for sqrt_32b_pipe: slot-level reference model plus directed literal checks.
module tb_sqrt_32b_pipe;
    localparam int LAT = 4;

    logic        Clock    = 1'b0;
    logic        Resetn   = 1'b0;
    logic        Enable   = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] X        = '0;
    logic        out_valid;
    logic [15:0] root;
    logic [16:0] rem;

    int total = 0;
    int bad   = 0;

    always #5 Clock = ~Clock;

    sqrt_32b_pipe #(.W_OUT(16), .BITS_PER_STAGE(4)) dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .Enable   (Enable),
        .in_valid (in_valid),
        .X        (X),
        .out_valid(out_valid),
        .root     (root),
        .rem      (rem)
    );

    // floor(sqrt(x)) by binary search over the root range
    function automatic void ref_sqrt(input logic [31:0] x, output longint r, output longint m);
        longint lo, hi, mid, xv;
        xv = longint'(x);
        lo = 0;
        hi = 65535;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= xv) lo = mid;
            else hi = mid - 1;
        end
        r = lo;
        m = xv - lo * lo;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Slot model: each enabled edge admits one slot (operand or bubble)
    logic        mv [LAT];
    logic [31:0] mx [LAT];

    always @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < LAT; i++) mv[i] <= 1'b0;
        end else if (Enable) begin
            mv[0] <= in_valid;
            mx[0] <= X;
            for (int i = 1; i < LAT; i++) begin
                mv[i] <= mv[i-1];
                mx[i] <= mx[i-1];
            end
        end
    end

    longint cr, cm;
    always @(negedge Clock) begin
        if (!Resetn) begin
            check("out_valid_in_reset", out_valid, 0);
        end else begin
            check("out_valid", out_valid, mv[LAT-1]);
            if (mv[LAT-1]) begin
                ref_sqrt(mx[LAT-1], cr, cm);
                check("root", root, cr);
                check("rem", rem, cm);
            end
        end
    end

    task automatic cyc(input logic en, input logic v, input logic [31:0] x);
        Enable   = en;
        in_valid = v;
        X        = x;
        @(posedge Clock);
        #1;
    endtask

    task automatic directed(input logic [31:0] x, input longint er, input longint em);
        cyc(1'b1, 1'b1, x);
        cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, '0);
        check("directed_not_early", out_valid, 0);
        cyc(1'b1, 1'b0, '0);
        check("directed_valid", out_valid, 1);
        check("directed_root", root, er);
        check("directed_rem", rem, em);
    endtask

    longint hr, hm;
    int     waited;

    initial begin
        // Pin the model against hand-computed values
        ref_sqrt(32'd0, hr, hm);          check("model_0_r", hr, 0);         check("model_0_m", hm, 0);
        ref_sqrt(32'hFFFFFFFF, hr, hm);   check("model_max_r", hr, 65535);   check("model_max_m", hm, 131070);
        ref_sqrt(32'd4294836225, hr, hm); check("model_sq_r", hr, 65535);    check("model_sq_m", hm, 0);
        ref_sqrt(32'd17, hr, hm);         check("model_17_r", hr, 4);        check("model_17_m", hm, 1);
        ref_sqrt(32'd99, hr, hm);         check("model_99_r", hr, 9);        check("model_99_m", hm, 18);

        repeat (3) cyc(1'b1, 1'b1, 32'h12345678);
        Resetn = 1'b1;
        cyc(1'b1, 1'b0, '0);

        directed(32'd0, 0, 0);
        directed(32'hFFFFFFFF, 65535, 131070);
        directed(32'd4294836225, 65535, 0);
        directed(32'd1000000, 1000, 0);
        directed(32'd80, 8, 16);

        for (int k = 0; k < 4096; k++) cyc(1'b1, 1'b1, 32'(k * k));
        for (int k = 1; k < 4096; k++) cyc(1'b1, 1'b1, 32'(k * k - 1));

        for (int x = 0; x < 65536; x += 251) cyc(1'b1, 1'b1, 32'(x) * 32'(x));
        cyc(1'b1, 1'b1, 32'd65535 * 32'd65535);

        // Enable held low for 3 cycles with bubbles around it
        for (int i = 0; i < 30; i++)
            cyc((i >= 10 && i < 13) ? 1'b0 : 1'b1, (i % 3) != 1, $urandom);

        for (int i = 0; i < 300; i++)
            cyc($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
                ($urandom_range(0, 9) == 0) ? 32'hFFFE0001 : $urandom);

        // Asynchronous reset with operands in flight and one at the output
        cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, '0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 32'(1000 + i));
        check("pre_reset_valid", out_valid, 1);
        #2 Resetn = 1'b0;
        #1 check("async_reset_valid", out_valid, 0);
        check("async_reset_root", root, 0);
        @(posedge Clock); #1;
        cyc(1'b1, 1'b1, 32'd77);
        Resetn = 1'b1;
        cyc(1'b1, 1'b1, 32'd144);
        Enable   = 1'b1;
        in_valid = 1'b0;
        waited   = 0;
        while (!out_valid && waited < 10) begin
            @(posedge Clock); #1;
            waited++;
        end
        check("post_reset_latency", waited, LAT - 1);
        check("post_reset_first_root", root, 12);
        check("post_reset_first_rem", rem, 0);

        repeat (LAT + 2) cyc(1'b1, 1'b0, '0);
        @(negedge Clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
